// File: rtl/dcache_valid_ctrl_pkg.sv
// Shared dcache definitions for the valid-array controller: geometry,
// derived widths, the controller FSM states and the arbitration grant codes.
package dcache_valid_ctrl_pkg;

    localparam int DCACHE_SETS  = 64;
    localparam int DCACHE_WAYS  = 8;
    localparam int DCACHE_IDX_W = $clog2(DCACHE_SETS);
    localparam int DCACHE_WAY_W = $clog2(DCACHE_WAYS);

    // INIT sweeps after reset, SWEEP sweeps after a flush, IDLE arbitrates.
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SWEEP
    } vc_state_t;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LOOKUP,
        GNT_FILL,
        GNT_INV
    } vc_grant_t;

endpackage

// File: rtl/dcache_valid_ctrl_if.sv
// Bundle of the requester handshakes, flush control and RAM port signals
// around the dcache valid-array controller.
interface dcache_valid_ctrl_if
    import dcache_valid_ctrl_pkg::*;
#(
    parameter int SETS = DCACHE_SETS,
    parameter int WAYS = DCACHE_WAYS
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic             lookup_valid;
    logic             lookup_ready;
    logic [IDX_W-1:0] lookup_index;

    logic             fill_valid;
    logic             fill_ready;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;

    logic             inv_valid;
    logic             inv_ready;
    logic [IDX_W-1:0] inv_index;
    logic [WAY_W-1:0] inv_way;

    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;

    logic             ram_cen;
    logic             ram_wen;
    logic [WAYS-1:0]  ram_bwen;
    logic [WAYS-1:0]  ram_din;
    logic [IDX_W-1:0] ram_addr;

    modport master (
        output lookup_valid, lookup_index,
        output fill_valid, fill_index, fill_way,
        output inv_valid, inv_index, inv_way,
        output flush_req,
        input  lookup_ready, fill_ready, inv_ready,
        input  flush_busy, flush_done,
        input  ram_cen, ram_wen, ram_bwen, ram_din, ram_addr
    );

    modport slave (
        input  lookup_valid, lookup_index,
        input  fill_valid, fill_index, fill_way,
        input  inv_valid, inv_index, inv_way,
        input  flush_req,
        output lookup_ready, fill_ready, inv_ready,
        output flush_busy, flush_done,
        output ram_cen, ram_wen, ram_bwen, ram_din, ram_addr
    );

endinterface

// File: rtl/dcache_valid_ctrl_onehot_dec.sv
// Way number to one-hot way mask; used for both fill and invalidate
// bit write-enables.
module dcache_valid_ctrl_onehot_dec
    import dcache_valid_ctrl_pkg::*;
#(
    parameter  int WAYS  = DCACHE_WAYS,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAY_W-1:0] way,
    output logic [WAYS-1:0]  mask
);

    // Exactly one bit set, at the selected way.
    always_comb begin
        mask      = '0;
        mask[way] = 1'b1;
    end

endmodule

// File: rtl/dcache_valid_ctrl.sv
// Arbiter and sequencer for the single-port dcache valid array. Shares the
// RAM port between lookup reads, fill sets and invalidate clears, and owns
// the whole-array clear sweep run after reset and on flush.
module dcache_valid_ctrl
    import dcache_valid_ctrl_pkg::*;
#(
    parameter int SETS          = DCACHE_SETS,
    parameter int WAYS          = DCACHE_WAYS,
    parameter int STARVE_MAX    = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    dcache_valid_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_SET    = IDX_W'(SETS - 1);
    localparam logic [STV_W-1:0] STARVE_LIM  = STV_W'(STARVE_MAX);
    localparam vc_state_t        RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_IDLE;

    vc_state_t        state;
    vc_state_t        state_next;
    vc_grant_t        grant;
    logic [IDX_W-1:0] sweep_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic [STV_W-1:0] starve_next;
    logic [WAYS-1:0]  fill_mask;
    logic [WAYS-1:0]  inv_mask;
    logic             write_pending;
    logic             write_ok;

    assign write_pending = bus.fill_valid | bus.inv_valid;
    assign write_ok      = (starve_cnt == STARVE_LIM) | ~bus.lookup_valid;

    dcache_valid_ctrl_onehot_dec #(.WAYS(WAYS)) u_fill_dec (
        .way  (bus.fill_way),
        .mask (fill_mask)
    );

    dcache_valid_ctrl_onehot_dec #(.WAYS(WAYS)) u_inv_dec (
        .way  (bus.inv_way),
        .mask (inv_mask)
    );

    // Arbitration, next state, RAM/handshake outputs and the next starve count.
    always_comb begin
        grant            = GNT_NONE;
        state_next       = state;
        starve_next      = starve_cnt;
        bus.lookup_ready = 1'b0;
        bus.fill_ready   = 1'b0;
        bus.inv_ready    = 1'b0;
        bus.flush_busy   = 1'b0;
        bus.flush_done   = 1'b0;
        bus.ram_cen      = 1'b0;
        bus.ram_wen      = 1'b0;
        bus.ram_bwen     = '0;
        bus.ram_din      = '0;
        bus.ram_addr     = '0;

        if (reset) begin
            bus.flush_busy = INIT_ON_RESET;
        end else begin
            case (state)
                ST_INIT, ST_SWEEP: begin
                    bus.flush_busy = 1'b1;
                    bus.ram_cen    = 1'b1;
                    bus.ram_wen    = 1'b1;
                    bus.ram_bwen   = '1;
                    bus.ram_addr   = sweep_cnt;
                    if (sweep_cnt == LAST_SET) begin
                        bus.flush_done = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.flush_req) begin
                        state_next = ST_SWEEP;
                    end else if (bus.fill_valid && write_ok) begin
                        grant = GNT_FILL;
                    end else if (bus.inv_valid && write_ok) begin
                        grant = GNT_INV;
                    end else if (bus.lookup_valid) begin
                        grant = GNT_LOOKUP;
                    end
                end
                default: state_next = RESET_STATE;
            endcase
        end

        case (grant)
            GNT_FILL: begin
                bus.fill_ready = 1'b1;
                bus.ram_cen    = 1'b1;
                bus.ram_wen    = 1'b1;
                bus.ram_addr   = bus.fill_index;
                bus.ram_bwen   = fill_mask;
                bus.ram_din    = fill_mask;
            end
            GNT_INV: begin
                bus.inv_ready = 1'b1;
                bus.ram_cen   = 1'b1;
                bus.ram_wen   = 1'b1;
                bus.ram_addr  = bus.inv_index;
                bus.ram_bwen  = inv_mask;
            end
            GNT_LOOKUP: begin
                bus.lookup_ready = 1'b1;
                bus.ram_cen      = 1'b1;
                bus.ram_addr     = bus.lookup_index;
            end
            default: ;
        endcase

        if (grant == GNT_LOOKUP && write_pending) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_next = starve_cnt + 1'b1;
            end
        end else if (grant == GNT_FILL || grant == GNT_INV || !write_pending) begin
            starve_next = '0;
        end
    end

    // FSM state register and sweep address counter; the counter only moves while sweeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RESET_STATE;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (state != ST_IDLE) begin
                sweep_cnt <= (sweep_cnt == LAST_SET) ? '0 : sweep_cnt + 1'b1;
            end
        end
    end

    // Count of lookups granted back-to-back while a write has been waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

endmodule

// File: tb/tb_dcache_valid_ctrl.sv
// Self-checking bench for dcache_valid_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the arbiter and sweep.
module tb_dcache_valid_ctrl;

    logic clock = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: sweep in progress, sweep position, starve count.
    bit m_sweep  = 1'b1;
    int m_pos    = 0;
    int m_starve = 0;
    bit m_gnt_lookup, m_gnt_fill, m_gnt_inv;

    always #5 clock = ~clock;

    dcache_valid_ctrl_if bus ();

    dcache_valid_ctrl #(
        .SETS          (64),
        .WAYS          (8),
        .STARVE_MAX    (4),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic applyStimulus(input bit lv, input int li, input bit fv, input int fi,
                                 input int fw, input bit iv, input int ii, input int iw,
                                 input bit fr);
        bus.lookup_valid = lv;
        bus.lookup_index = 6'(li);
        bus.fill_valid   = fv;
        bus.fill_index   = 6'(fi);
        bus.fill_way     = 3'(fw);
        bus.inv_valid    = iv;
        bus.inv_index    = 6'(ii);
        bus.inv_way      = 3'(iw);
        bus.flush_req    = fr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic waitFillGrant(output int lookups, output int at_cycle);
        lookups  = 0;
        at_cycle = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (bus.fill_ready) begin
                at_cycle = c;
                break;
            end
            if (bus.lookup_ready) lookups++;
        end
    endtask

    // Every cycle: derive the required outputs from the model, compare, then advance the model.
    always @(negedge clock) begin : compare_proc
        bit          g_l, g_f, g_i, wr_pend, wr_ok;
        logic        e_busy, e_done, e_cen, e_wen;
        logic [7:0]  e_bwen, e_din;
        logic [5:0]  e_addr;
        logic [28:0] exp_v, act_v;
        g_l = 0; g_f = 0; g_i = 0;
        e_busy = 0; e_done = 0; e_cen = 0; e_wen = 0;
        e_bwen = 0; e_din = 0; e_addr = 0;
        wr_pend = bus.fill_valid || bus.inv_valid;
        if (reset) begin
            e_busy   = 1;
            m_sweep  = 1;
            m_pos    = 0;
            m_starve = 0;
        end else if (m_sweep) begin
            e_busy = 1; e_cen = 1; e_wen = 1; e_bwen = 8'hFF;
            e_addr = 6'(m_pos);
            if (m_pos == 63) begin
                e_done  = 1;
                m_sweep = 0;
                m_pos   = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (!wr_pend) m_starve = 0;
        end else begin
            wr_ok = (m_starve >= 4) || !bus.lookup_valid;
            if (bus.flush_req) begin
                m_sweep = 1;
                m_pos   = 0;
            end else if (bus.fill_valid && wr_ok) g_f = 1;
            else if (bus.inv_valid && wr_ok) g_i = 1;
            else if (bus.lookup_valid) g_l = 1;
            if (g_f) begin
                e_cen = 1; e_wen = 1; e_addr = bus.fill_index;
                e_bwen = 8'h01 << bus.fill_way; e_din = e_bwen;
            end
            if (g_i) begin
                e_cen = 1; e_wen = 1; e_addr = bus.inv_index;
                e_bwen = 8'h01 << bus.inv_way;
            end
            if (g_l) begin
                e_cen = 1; e_addr = bus.lookup_index;
            end
            if (g_l && wr_pend) m_starve = (m_starve + 1 > 4) ? 4 : m_starve + 1;
            else if (g_f || g_i || !wr_pend) m_starve = 0;
        end
        exp_v = {g_l, g_f, g_i, e_busy, e_done, e_cen, e_wen, e_bwen, e_din, e_addr};
        act_v = {bus.lookup_ready, bus.fill_ready, bus.inv_ready, bus.flush_busy,
                 bus.flush_done, bus.ram_cen, bus.ram_wen, bus.ram_bwen, bus.ram_din,
                 bus.ram_addr};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL model_cmp t=%0t actual=0x%h required=0x%h", $time, act_v, exp_v);
        end
        m_gnt_lookup = g_l;
        m_gnt_fill   = g_f;
        m_gnt_inv    = g_i;
    end

    // Hard time limit so the bench always reaches its summary.
    initial begin
        #600000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int  first_done, done_cnt, lk, cyc;
        bit  pl, pf, pi;
        int  li, fi, fw, ii, iw;

        reset = 1'b1;
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("reset_busy", bus.flush_busy, 1);
        checkOutput("reset_cen", bus.ram_cen, 0);
        checkOutput("reset_lookup_ready", bus.lookup_ready, 0);
        nextCycle();
        reset = 1'b0;

        first_done = 0;
        done_cnt   = 0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clock);
            if (bus.flush_done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k == 1) begin
                checkOutput("init_first_addr", bus.ram_addr, 0);
                checkOutput("init_bwen", bus.ram_bwen, 8'hFF);
                checkOutput("init_din", bus.ram_din, 0);
                checkOutput("init_lookup_blocked", bus.lookup_ready, 0);
            end
            if (k == 64) begin
                checkOutput("init_last_addr", bus.ram_addr, 63);
                checkOutput("init_busy_last", bus.flush_busy, 1);
            end
            if (k == 65) begin
                checkOutput("init_first_grant", bus.lookup_ready, 1);
                checkOutput("init_first_grant_addr", bus.ram_addr, 7);
                checkOutput("init_busy_after", bus.flush_busy, 0);
            end
        end
        checkOutput("init_done_cycle", first_done, 64);
        checkOutput("init_done_count", done_cnt, 1);

        nextCycle();
        applyStimulus(0, 0, 1, 5, 3, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("fill_ready", bus.fill_ready, 1);
        checkOutput("fill_bwen", bus.ram_bwen, 8'h08);
        checkOutput("fill_din", bus.ram_din, 8'h08);
        checkOutput("fill_addr", bus.ram_addr, 5);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 3, 0);
        @(negedge clock);
        checkOutput("inv_ready", bus.inv_ready, 1);
        checkOutput("inv_bwen", bus.ram_bwen, 8'h08);
        checkOutput("inv_din", bus.ram_din, 8'h00);

        nextCycle();
        applyStimulus(1, 9, 1, 2, 6, 0, 0, 0, 0);
        waitFillGrant(lk, cyc);
        checkOutput("starve_lookups", lk, 4);
        checkOutput("starve_fill_cycle", cyc, 5);
        nextCycle();
        applyStimulus(1, 9, 1, 3, 1, 0, 0, 0, 0);
        waitFillGrant(lk, cyc);
        checkOutput("starve_cleared_lookups", lk, 4);
        checkOutput("starve_cleared_cycle", cyc, 5);

        nextCycle();
        applyStimulus(0, 0, 1, 1, 0, 1, 1, 0, 0);
        @(negedge clock);
        checkOutput("both_fill_first", bus.fill_ready, 1);
        checkOutput("both_inv_waits", bus.inv_ready, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clock);
        checkOutput("both_inv_next", bus.inv_ready, 1);
        checkOutput("both_inv_bwen", bus.ram_bwen, 8'h01);

        nextCycle();
        applyStimulus(1, 12, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("stream_lookup", bus.lookup_ready, 1);
        nextCycle();
        applyStimulus(1, 12, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        checkOutput("flush_no_grant", bus.lookup_ready, 0);
        checkOutput("flush_no_cen", bus.ram_cen, 0);
        first_done = 0;
        done_cnt   = 0;
        for (int k = 1; k <= 70; k++) begin
            nextCycle();
            bus.flush_req = (k == 20 || k == 64);
            @(negedge clock);
            if (bus.flush_done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k == 1) checkOutput("sweep_first_addr", bus.ram_addr, 0);
            if (k == 65) checkOutput("sweep_then_grant", bus.lookup_ready, 1);
        end
        checkOutput("sweep_done_cycle", first_done, 64);
        checkOutput("sweep_done_count", done_cnt, 1);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        done_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            if (bus.flush_done) done_cnt++;
        end
        checkOutput("abort_at_addr30", bus.ram_addr, 30);
        nextCycle();
        reset = 1'b1;
        @(negedge clock);
        if (bus.flush_done) done_cnt++;
        checkOutput("abort_no_done", done_cnt, 0);
        nextCycle();
        reset = 1'b0;
        first_done = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            if (k == 1) checkOutput("abort_restart_addr", bus.ram_addr, 0);
            if (bus.flush_done && first_done == 0) first_done = k;
        end
        checkOutput("abort_done_cycle", first_done, 64);

        pl = 0; pf = 0; pi = 0;
        li = 0; fi = 0; fw = 0; ii = 0; iw = 0;
        for (int n = 0; n < 3000; n++) begin
            nextCycle();
            if (pl && m_gnt_lookup) pl = 0;
            if (pf && m_gnt_fill) pf = 0;
            if (pi && m_gnt_inv) pi = 0;
            if (!pl && $urandom_range(0, 1) == 1) begin
                pl = 1; li = int'($urandom_range(0, 63));
            end
            if (!pf && $urandom_range(0, 2) == 0) begin
                pf = 1; fi = int'($urandom_range(0, 63)); fw = int'($urandom_range(0, 7));
            end
            if (!pi && $urandom_range(0, 3) == 0) begin
                pi = 1; ii = int'($urandom_range(0, 63)); iw = int'($urandom_range(0, 7));
            end
            reset = ($urandom_range(0, 799) == 0);
            applyStimulus(pl, li, pf, fi, fw, pi, ii, iw, $urandom_range(0, 199) == 0);
        end

        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
